clkout_ctrl: RTL and testbench

CLKOUT_CTRL -- requirements
Module: clkout_ctrl

---
 rtl/clkout_pkg.sv | 14 +
 rtl/phase_timer.sv | 32 +++
 rtl/clkout_ctrl.sv | 137 +++++++++++++
 tb/tb_clkout_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/clkout_pkg.sv
// Shared definitions for the clkout controller: FSM state encoding and
// default widths of the configuration fields.
package clkout_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/phase_timer.sv
// Down-counter timing one clkout phase. Loading value N makes tick rise
// N cycles later and stay high while the count sits at zero, so a phase
// loaded with cfg_half lasts exactly cfg_half+1 cycles.
module phase_timer
    import clkout_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_value,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // Load a new phase length, otherwise count down and park at zero.
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/clkout_ctrl.sv
// Burst / free-running clock generator. clkout is a registered square wave
// with H = half_reg+1 cycles per phase. A burst ends after count_reg periods
// (count_reg = 0 runs until stopped); a stop request always lets the current
// phase finish and ends on a complete low phase, so no phase is ever short.
module clkout_ctrl
    import clkout_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_half,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             clkout,
    output logic             busy,
    output logic             done
);

    state_t           state, state_next;
    logic             clkout_next, busy_next, done_next;
    logic [DIV_W-1:0] half_reg, half_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] period_cnt, period_next;

    logic             timer_load;
    logic [DIV_W-1:0] timer_value;
    logic             tick;

    // A stop seen in RUN takes effect on the same cycle it arrives.
    logic stopping_now;
    // The low phase now ending is the last one of a finite burst.
    logic last_period;

    assign stopping_now = (state == STOPPING) || ((state == RUN) && stop);
    assign last_period  = (count_reg != '0) && (period_cnt == count_reg - 1'b1);

    phase_timer #(
        .DIV_W(DIV_W)
    ) u_phase_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .tick       (tick)
    );

    // Next-state and next-output decode for the burst FSM.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next  = state;
        clkout_next = clkout;
        busy_next   = busy;
        done_next   = 1'b0;
        half_next   = half_reg;
        count_next  = count_reg;
        period_next = period_cnt;
        timer_load  = 1'b0;
        timer_value = half_reg;

        case (state)
            IDLE: begin
                if (cfg_we) begin
                    half_next  = cfg_half;
                    count_next = cfg_count;
                end
                if (start) begin
                    state_next  = RUN;
                    clkout_next = 1'b1;
                    busy_next   = 1'b1;
                    period_next = '0;
                    timer_load  = 1'b1;
                    // A same-cycle config write applies to this burst.
                    timer_value = cfg_we ? cfg_half : half_reg;
                end
            end

            RUN, STOPPING: begin
                if (stopping_now) begin
                    state_next = STOPPING;
                end
                if (tick) begin
                    if (clkout) begin
                        // High phase over: a full low phase always follows.
                        clkout_next = 1'b0;
                        timer_load  = 1'b1;
                    end else begin
                        // Low phase over: one period complete, saturating.
                        if (period_cnt != '1) begin
                            period_next = period_cnt + 1'b1;
                        end
                        if (stopping_now || last_period) begin
                            state_next  = IDLE;
                            busy_next   = 1'b0;
                            done_next   = 1'b1;
                            period_next = '0;
                        end else begin
                            clkout_next = 1'b1;
                            timer_load  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_next  = IDLE;
                clkout_next = 1'b0;
                busy_next   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            clkout     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            half_reg   <= '0;
            count_reg  <= '0;
            period_cnt <= '0;
        end else begin
            state      <= state_next;
            clkout     <= clkout_next;
            busy       <= busy_next;
            done       <= done_next;
            half_reg   <= half_next;
            count_reg  <= count_next;
            period_cnt <= period_next;
        end
    end

endmodule

// File: tb/tb_clkout_ctrl.sv
// Self-checking bench for clkout_ctrl: a table of per-cycle vectors for
// reset / stop / start corner cases, directed bursts, and randomized bursts
// compared against a waveform model derived from phase arithmetic.
module tb_clkout_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_half = '0;
    logic [15:0] cfg_count = '0;
    logic        clkout, busy, done;

    int checks = 0;
    int failures = 0;

    // Bench copy of the configuration registers, updated only by idle writes.
    int m_half = 0;
    int m_count = 0;

    always #5 clock = ~clock;

    clkout_ctrl #(
        .DIV_W(8),
        .CNT_W(16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .cfg_we    (cfg_we),
        .cfg_half  (cfg_half),
        .cfg_count (cfg_count),
        .clkout    (clkout),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic        rst;
        logic        st;
        logic        sp;
        logic        we;
        logic [7:0]  half;
        logic [15:0] count;
        logic        exp_clk;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic p, input logic w,
                                input logic [7:0] h, input logic [15:0] c,
                                input logic ec, input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.st = s; v.sp = p; v.we = w; v.half = h; v.count = c;
        v.exp_clk = ec; v.exp_busy = eb; v.exp_done = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic ec, input logic eb, input logic ed);
        check($sformatf("%s clkout", tag), clkout, ec);
        check($sformatf("%s busy", tag), busy, eb);
        check($sformatf("%s done", tag), done, ed);
    endtask

    // Drive one cycle of inputs, clock it, and settle just after the edge.
    task automatic step(input logic r, input logic s, input logic p, input logic w,
                        input logic [7:0] h, input logic [15:0] c);
        reset = r; start = s; stop = p; cfg_we = w; cfg_half = h; cfg_count = c;
        @(posedge clock);
        #1;
    endtask

    // Last busy cycle of a burst counted from the first cycle after start.
    // Phase p (0-based) covers cycles p*H+1 .. (p+1)*H; even phases are high.
    function automatic int burst_end(input int h, input int c, input int s);
        int fin;
        int p;
        fin = (c == 0) ? 1000000 : 2 * h * c;
        if (s >= 1 && s <= fin) begin
            p = (s - 1) / h;
            if (p % 2 == 0) begin
                if ((p + 2) * h < fin) fin = (p + 2) * h;
            end else begin
                if ((p + 1) * h < fin) fin = (p + 1) * h;
            end
        end
        return fin;
    endfunction

    task automatic model_at(input int k, input int h, input int fin,
                            output logic ec, output logic eb, output logic ed);
        if (k <= fin) begin
            ec = (((k - 1) / h) % 2 == 0);
            eb = 1'b1;
            ed = 1'b0;
        end else begin
            ec = 1'b0;
            eb = 1'b0;
            ed = (k == fin + 1);
        end
    endtask

    // One burst from idle. s = cycle during which stop is held (0 = none);
    // noise adds ignored start/cfg_we/stop pulses; inj_k injects a
    // cfg_we(half=5)+start pulse mid-run.
    task automatic run_burst(input string tag, input bit use_cfg, input int h, input int c,
                             input int s, input bit noise, input int inj_k);
        int   hh;
        int   fin;
        logic ec, eb, ed;
        logic st, sp, we;
        if (use_cfg) begin
            m_half  = h;
            m_count = c;
        end
        hh  = m_half + 1;
        fin = burst_end(hh, m_count, s);
        step(1'b0, 1'b1, 1'b0, use_cfg, 8'(h), 16'(c));
        model_at(1, hh, fin, ec, eb, ed);
        check_outs($sformatf("%s k=1", tag), ec, eb, ed);
        for (int k = 1; k <= fin + 1; k++) begin
            st = 1'b0; sp = (k == s); we = 1'b0;
            if (noise && k <= fin) begin
                st = ($urandom_range(0, 3) == 0);
                we = ($urandom_range(0, 2) == 0);
            end
            if (noise && s > 0 && k > s) sp = 1'(($urandom_range(0, 1)));
            if (k == inj_k) begin
                st = 1'b1;
                we = 1'b1;
            end
            step(1'b0, st, sp, we, (k == inj_k) ? 8'd5 : 8'($urandom_range(0, 255)),
                 16'($urandom_range(0, 65535)));
            model_at(k + 1, hh, fin, ec, eb, ed);
            check_outs($sformatf("%s k=%0d", tag, k + 1), ec, eb, ed);
        end
    endtask

    initial begin
        int hh, cc, s, hq, cq;
        bit use_cfg;

        // Reset mid-run, reset priority, stop on 2nd high cycle at clock/2,
        // stop ignored in idle, start+stop in idle, start ignored while stopping.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 2, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 3, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].we, vecs[i].half, vecs[i].count);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_clk, vecs[i].exp_busy, vecs[i].exp_done);
        end
        m_half  = 0;
        m_count = 0;

        // 3-high/3-low x3, busy for 18 cycles, then one done.
        run_burst("burst_h2_c3", 1'b1, 2, 3, 0, 1'b0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_outs("burst_h2_c3 idle", 1'b0, 1'b0, 1'b0);

        // Config write and start during RUN are ignored; next burst keeps half=1.
        run_burst("run_cfg_ignored", 1'b1, 1, 0, 13, 1'b0, 2);
        run_burst("reuse_half", 1'b0, 0, 0, 7, 1'b0, 0);

        // Single-period burst with stop held in its final low cycle.
        run_burst("stop_last_low", 1'b1, 1, 1, 4, 1'b0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_outs("stop_last_low idle", 1'b0, 1'b0, 1'b0);

        // Randomized bursts with ignored-input noise.
        for (int n = 0; n < 40; n++) begin
            use_cfg = ($urandom_range(0, 3) != 0);
            hq = $urandom_range(0, 3);
            cq = $urandom_range(0, 4);
            hh = (use_cfg ? hq : m_half) + 1;
            cc = use_cfg ? cq : m_count;
            if (cc == 0) s = $urandom_range(1, 30);
            else if ($urandom_range(0, 3) == 0) s = 0;
            else s = $urandom_range(1, 2 * hh * cc);
            run_burst($sformatf("rand%0d", n), use_cfg, hq, cq, s, 1'b1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
